// File: rtl/mem_dump.sv
// Result-readout unit: on a rising halt, sweeps a fixed data-memory window
// through a read-only port and streams each word out over valid/ready.
//
// state | meaning
// IDLE  | waiting for a rising edge of halt
// RD    | read strobe and address presented to data memory
// CAP   | read data captured into the output register
// SEND  | word held on dout until the consumer accepts it
// FIN   | dump complete; done held until halt falls
module mem_dump #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int BASE  = 16,
  parameter int COUNT = 3
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          halt,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  localparam logic [AW-1:0] BASE_A   = AW'(BASE);
  // index is one bit wider than the address so a full 2^AW window is legal
  localparam logic [AW:0]   LAST_IDX = (COUNT == 0) ? '0 : (AW+1)'(COUNT - 1);

  logic [2:0]  state;
  logic        halt_q;
  logic [AW:0] index;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      halt_q     <= 1'b0;
      index      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      halt_q <= halt;
      case (state)
        IDLE: begin
          if (halt && !halt_q) begin
            index <= '0;
            state <= (COUNT == 0) ? FIN : RD;
          end
        end
        RD: state <= CAP;
        CAP: begin
          dout       <= mem_rd_data;
          dout_valid <= 1'b1;
          dout_last  <= (index == LAST_IDX);
          state      <= SEND;
        end
        SEND: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            if (dout_last) begin
              state <= FIN;
            end else begin
              index <= index + 1'b1;
              state <= RD;
            end
          end
        end
        FIN: begin
          if (!halt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address arithmetic is modulo 2^AW so windows may wrap past the top
  assign mem_rd_en = (state == RD);
  assign mem_addr  = BASE_A + index[AW-1:0];
  assign busy      = (state == RD) || (state == CAP) || (state == SEND);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_mem_dump.sv
// Directed bench for mem_dump: three instances (default window, wrapping
// window, empty window) share clock, reset, halt and dout_ready.
module tb_mem_dump;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic Reset, halt, dout_ready;
  logic [7:0] mem [256];

  logic       rd_en0, rd_en1, rd_en2;
  logic [7:0] addr0, addr1, addr2;
  logic [7:0] rdd0, rdd1, rdd2;
  logic [7:0] dout0, dout1, dout2;
  logic       valid0, valid1, valid2;
  logic       last0, last1, last2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  mem_dump u0 (.CLK(CLK), .Reset(Reset), .halt(halt), .mem_rd_en(rd_en0), .mem_addr(addr0),
               .mem_rd_data(rdd0), .dout(dout0), .dout_valid(valid0), .dout_ready(dout_ready),
               .dout_last(last0), .busy(busy0), .done(done0));
  mem_dump #(.BASE(254)) u1 (.CLK(CLK), .Reset(Reset), .halt(halt), .mem_rd_en(rd_en1),
               .mem_addr(addr1), .mem_rd_data(rdd1), .dout(dout1), .dout_valid(valid1),
               .dout_ready(dout_ready), .dout_last(last1), .busy(busy1), .done(done1));
  mem_dump #(.COUNT(0)) u2 (.CLK(CLK), .Reset(Reset), .halt(halt), .mem_rd_en(rd_en2),
               .mem_addr(addr2), .mem_rd_data(rdd2), .dout(dout2), .dout_valid(valid2),
               .dout_ready(dout_ready), .dout_last(last2), .busy(busy2), .done(done2));

  // One-cycle-latency read ports
  always @(posedge CLK) begin
    if (rd_en0) rdd0 <= mem[addr0];
    if (rd_en1) rdd1 <= mem[addr1];
    if (rd_en2) rdd2 <= mem[addr2];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: records handshakes that will complete at the coming edge
  logic [8:0] w0[$], w1[$];
  int         c0[$];
  logic [7:0] a0[$], a1[$], a2[$];
  int         v2cnt = 0;
  always @(negedge CLK) begin
    #1;
    if (!Reset) begin
      if (valid0 && dout_ready) begin w0.push_back({last0, dout0}); c0.push_back(cyc); end
      if (valid1 && dout_ready) w1.push_back({last1, dout1});
      if (rd_en0) a0.push_back(addr0);
      if (rd_en1) a1.push_back(addr1);
      if (rd_en2) a2.push_back(addr2);
      if (valid2) v2cnt = v2cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_dump0(input string nm, input int start);
    logic [8:0] e [3];
    e[0] = 9'h000; e[1] = 9'h010; e[2] = 9'h100;
    check({nm, "_count"}, 64'(w0.size() - start), 64'd3);
    if (w0.size() - start == 3)
      for (int k = 0; k < 3; k++) check({nm, "_word"}, 64'(w0[start+k]), 64'(e[k]));
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n = 0;
    do begin @(posedge CLK); #1; n++; end while (!valid0 && n < budget);
    if (!valid0) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for dout_valid got 0 expected 1", nm);
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    do begin @(posedge CLK); #1; n++; end while (!done0 && n < budget);
    if (!done0) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for done got 0 expected 1", nm);
    end
  endtask

  typedef struct {
    logic       halt;
    logic       ready;
    logic       rd_en;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] dout;
    logic       last;
    logic       busy;
    logic       done;
    logic       done2;
  } vec_t;

  vec_t tv [13];

  initial begin
    int m0, m1, ma0, ma1, ok;
    logic [63:0] act, exp;

    // halt ready rd_en addr valid dout last busy done done2
    tv[0]  = '{1'b1, 1'b1, 1'b1, 8'd16, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 8'd16, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 8'd16, 1'b1, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 1'b1, 1'b1, 8'd17, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 8'd17, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 8'd17, 1'b1, 8'd16, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 8'd18, 1'b0, 8'd16, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 8'd18, 1'b0, 8'd16, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[8]  = '{1'b1, 1'b1, 1'b0, 8'd18, 1'b1, 8'd0,  1'b1, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b1, 1'b0, 8'd18, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1};
    tv[10] = '{1'b1, 1'b1, 1'b0, 8'd18, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1};
    tv[11] = '{1'b0, 1'b1, 1'b0, 8'd18, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b1, 1'b0, 8'd18, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 256; i++) mem[i] = 8'h5A;
    mem[16] = 8'h00; mem[17] = 8'h10; mem[18] = 8'h00;
    mem[254] = 8'hAA; mem[255] = 8'hBB; mem[0] = 8'hCC;

    Reset = 1'b1; halt = 1'b0; dout_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rd_en", 64'(rd_en0), 64'd0);
    check("rst_addr", 64'(addr0), 64'd16);
    check("rst_addr_wrap", 64'(addr1), 64'd254);
    check("rst_dout", 64'(dout0), 64'd0);
    check("rst_valid_last", 64'({valid0, last0}), 64'd0);
    check("rst_busy_done", 64'({busy0, done0, busy2, done2}), 64'd0);
    @(negedge CLK) Reset = 1'b0;

    // Test 1: basic dump, ready tied high (wrap and empty windows run alongside)
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      halt = tv[i].halt; dout_ready = tv[i].ready;
      @(posedge CLK); #1;
      act = {rd_en0, (tv[i].rd_en ? addr0 : 8'd0), valid0, dout0, last0, busy0, done0, done2};
      exp = {tv[i].rd_en, (tv[i].rd_en ? tv[i].addr : 8'd0), tv[i].valid, tv[i].dout,
             tv[i].last, tv[i].busy, tv[i].done, tv[i].done2};
      check($sformatf("vec%0d", i), act, exp);
    end
    check_dump0("t1_dump", 0);
    if (c0.size() >= 3) begin
      check("t1_gap01", 64'(c0[1] - c0[0]), 64'd3);
      check("t1_gap12", 64'(c0[2] - c0[1]), 64'd3);
    end
    check("t1_addrs", 64'({a0.size() == 3, a0.size() == 3 ? {a0[0], a0[1], a0[2]} : 24'd0}),
          64'({1'b1, 24'h101112}));
    check("t3_addrs_wrap",
          64'({a1.size() == 3, a1.size() == 3 ? {a1[0], a1[1], a1[2]} : 24'd0}),
          64'({1'b1, 24'hFEFF00}));
    check("t3_words_wrap",
          64'({w1.size() == 3, w1.size() == 3 ? {w1[0], w1[1], w1[2]} : 27'd0}),
          64'({1'b1, 9'h0AA, 9'h0BB, 9'h1CC}));

    // Test 2: consumer stalls for word 2
    m0 = w0.size(); ma0 = a0.size();
    @(negedge CLK);
    halt = 1'b1; dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid("t2_wait", 20);
      if (k == 1)
        for (int s = 0; s < 5; s++) begin
          @(posedge CLK); #1;
          check("t2_stall_hold", 64'({valid0, dout0, rd_en0}), 64'({1'b1, 8'd16, 1'b0}));
        end
      @(negedge CLK) dout_ready = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK) dout_ready = 1'b0;
    end
    check_dump0("t2_dump", m0);
    check("t2_rd_count", 64'(a0.size() - ma0), 64'd3);
    check("t2_done", 64'(done0), 64'd1);

    // Test 5: reset during SEND of word 2, halt held high across reset
    halt = 1'b0;
    @(negedge CLK);
    halt = 1'b1; dout_ready = 1'b1;
    wait_valid("t5_w1", 20);
    @(posedge CLK); #1;
    @(negedge CLK) dout_ready = 1'b0;
    wait_valid("t5_w2", 20);
    check("t5_word2", 64'(dout0), 64'd16);
    m1 = w0.size();
    @(negedge CLK) Reset = 1'b1;
    @(posedge CLK); #1;
    check("t5_abort", 64'({valid0, busy0, done0}), 64'd0);
    @(negedge CLK);
    Reset = 1'b0; dout_ready = 1'b1;
    check("t5_no_word", 64'(w0.size() - m1), 64'd0);
    m0 = w0.size();
    @(posedge CLK); #1;
    check("t5_restart", 64'({rd_en0, addr0}), 64'({1'b1, 8'd16}));
    wait_done("t5_done", 30);
    check_dump0("t5_dump", m0);

    // Test 6: held halt does not retrigger; new rising edge dumps again
    ma0 = a0.size(); ok = 0;
    for (int s = 0; s < 10; s++) begin
      @(posedge CLK); #1;
      if (done0 && !busy0) ok++;
    end
    check("t6_hold_done", 64'(ok), 64'd10);
    check("t6_no_retrig", 64'(a0.size() - ma0), 64'd0);
    @(negedge CLK) halt = 1'b0;
    @(posedge CLK); #1;
    check("t6_done_drop", 64'(done0), 64'd0);
    @(negedge CLK) halt = 1'b1;
    m0 = w0.size();
    wait_done("t6_done", 30);
    check_dump0("t6_dump", m0);

    // Test 4: empty window never touches memory or the stream
    check("t4_no_rd", 64'(a2.size()), 64'd0);
    check("t4_no_valid", 64'(v2cnt), 64'd0);
    check("t4_done", 64'(done2), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump.md
Name: mem_dump

Overview:
- Synthesizable result-readout unit; the hardware-side counterpart of the bench flow "preload memory, launch, wait for halt, read results".
- Sits beside TopLevel's data memory on a second, read-only port.
- On assertion of halt, sweeps a fixed address window of data memory and streams each byte out over a valid/ready channel.
- Signals completion so a host or bench can collect results without hierarchical peeks.

Parameters:
AW, 8, data memory address width
DW, 8, data word width
BASE, 16, first address dumped
COUNT, 3, number of words dumped (0..2^AW)

Ports:
CLK  input  1  clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
halt  input  1  done flag from TopLevel
mem_rd_en  output  1  read strobe to data memory read port
mem_addr  output  AW  read address
mem_rd_data  input  DW  read data; valid exactly 1 cycle after mem_rd_en
dout  output  DW  streamed memory word
dout_valid  output  1  dout holds a word
dout_ready  input  1  consumer accepts when valid && ready
dout_last  output  1  high with the final word of the window
busy  output  1  dump in progress
done  output  1  dump complete; held while halt stays high

Behaviour:
- Reset (sync, active-high) state and outputs:
  - state=IDLE, halt_q=0, index=0.
  - mem_rd_en=0, mem_addr=BASE[AW-1:0], dout=0, dout_valid=0, dout_last=0, busy=0, done=0.
  - Reset asserted mid-dump aborts immediately; no further words are emitted.
- Trigger:
  - halt_q <= halt every cycle.
  - trigger = halt && !halt_q, sampled in IDLE only.
  - Because halt_q resets to 0, halt already high when Reset deasserts triggers on the first cycle after reset.
- States:
  - IDLE: busy=0. On trigger: index<=0; if COUNT==0 go to FIN, else go to RD.
  - RD: mem_rd_en=1, mem_addr=(BASE+index) mod 2^AW (address wraps, e.g. BASE=254 gives 254,255,0). Next state CAP.
  - CAP: dout<=mem_rd_data; dout_valid<=1; dout_last<=(index==COUNT-1). Next state SEND.
  - SEND: hold dout, dout_valid and dout_last stable until dout_ready.
    - On handshake: dout_valid<=0, dout_last<=0.
    - If last, go to FIN; else index<=index+1 and go to RD.
  - FIN: done=1, busy=0. Leave for IDLE when halt==0 (done drops the same edge). A new halt rising edge is required to dump again.
- Outputs by state:
  - busy=1 in RD, CAP and SEND.
  - mem_rd_en is high only in RD, one cycle per word.
- Timing:
  - Latency from trigger edge to first dout_valid is 3 cycles (IDLE->RD->CAP->SEND).
  - Best-case throughput is one word per 3 cycles with dout_ready tied high.
- Corner cases:
  - halt dropping mid-dump does not abort: the dump completes, then FIN falls straight to IDLE.
  - dout_ready high while dout_valid is low is ignored.
  - index width is AW+1 so that COUNT=2^AW is legal.

Test Plan:
1. Memory[16..18]=0,16,0; Reset 1 then 0; halt rises, dout_ready=1 -> mem_addr 16,17,18 in RD cycles; dout = 0, 16, 0, accepted 3 cycles apart; dout_last only on the third word; done=1 after the third handshake.
2. Same memory; dout_ready low for 5 cycles during word 2 -> dout=16 and dout_valid held stable all 5 cycles; no extra mem_rd_en; exactly 3 words delivered.
3. BASE=254, COUNT=3, memory[254]=AA, [255]=BB, [0]=CC -> addresses 254,255,0; dout = AA, BB, CC.
4. COUNT=0; halt rises -> no mem_rd_en, no dout_valid; done=1 one cycle after the trigger.
5. Reset asserted in SEND of word 2 -> next cycle dout_valid=0, busy=0, done=0. Halt still high after reset release -> dump restarts from BASE.
6. Dump completes with done=1; halt stays high 10 cycles -> no retrigger. halt low 1 cycle -> done=0. halt high again -> second full dump.
